// File: rtl/meta_pkg.sv
// Shared widths and the metadata word type for the SOP metadata queue.
package meta_pkg;

  localparam int META_W_DFLT = 64;
  localparam int DROP_W_DFLT = 16;

  typedef logic [META_W_DFLT-1:0] meta_t;

endpackage : meta_pkg

// File: rtl/meta_fifo_mem.sv
// Register-array storage for the metadata queue: one write port and one
// combinational read port.
module meta_fifo_mem #(
  parameter int META_W = 64,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [META_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [META_W-1:0] rdata
);

  logic [META_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; the empty flag masks stale words.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule : meta_fifo_mem

// File: rtl/meta_sop_queue.sv
// Captures one metadata word per SOP pulse into a FWFT queue, presents it with
// valid/ready, throttles upstream via stall_out and counts dropped words.
module meta_sop_queue
  import meta_pkg::*;
#(
  parameter int  META_W    = META_W_DFLT,
  parameter int  DEPTH     = 8,
  parameter int  AF_MARGIN = 1,
  parameter int  DROP_W    = DROP_W_DFLT,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sop_pulse,
  input  logic [META_W-1:0] meta_in,
  output logic [META_W-1:0] meta_out,
  output logic              meta_out_valid,
  input  logic              meta_out_ready,
  output logic              stall_out,
  output logic [CW-1:0]     count,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [CW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              stall_q, stall_d;
  logic              empty, full, push, pop;
  logic [META_W-1:0] rdata;

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q ^ rptr_q) == FULL_XOR);
  assign pop   = !empty && meta_out_ready;
  assign push  = sop_pulse && (!full || pop);

  // NOTE: combinational next-state uses blocking '=' with defaults first, so no latches.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (sop_pulse && full && !pop && (drop_q != {DROP_W{1'b1}}))
      drop_d = drop_q + 1'b1;
    stall_d = (count_d >= AF_LEVEL);
  end

  // NOTE: state registers use non-blocking '<='; reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      stall_q <= stall_d;
    end
  end

  meta_fifo_mem #(
    .META_W (META_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wdata (meta_in),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign meta_out       = empty ? '0 : rdata;
  assign meta_out_valid = !empty;
  assign stall_out      = stall_q;
  assign count          = count_q;
  assign drop_cnt       = drop_q;

endmodule : meta_sop_queue

// File: tb/tb_meta_sop_queue.sv
// Directed self-checking bench for meta_sop_queue (DEPTH=8, AF_MARGIN=1).
module tb_meta_sop_queue;
  import meta_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sop_pulse;
  meta_t       meta_in;
  meta_t       meta_out;
  logic        meta_out_valid;
  logic        meta_out_ready;
  logic        stall_out;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  meta_sop_queue #(
    .META_W    (64),
    .DEPTH     (8),
    .AF_MARGIN (1),
    .DROP_W    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sop_pulse      (sop_pulse),
    .meta_in        (meta_in),
    .meta_out       (meta_out),
    .meta_out_valid (meta_out_valid),
    .meta_out_ready (meta_out_ready),
    .stall_out      (stall_out),
    .count          (count),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(meta_out_valid), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_stall"}, 64'(stall_out), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check({tag, "_data"}, meta_out, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sop_pulse = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sop_pulse = 1'b0; meta_in = '0; meta_out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_idle("reset");

    // 1. single word
    sop_pulse = 1'b1; meta_in = 64'hA5; meta_out_ready = 1'b1;
    tick();
    check("t1_valid", 64'(meta_out_valid), 64'd1);
    check("t1_data", meta_out, 64'hA5);
    check("t1_count", 64'(count), 64'd1);
    sop_pulse = 1'b0;
    tick();
    check("t1_pop_valid", 64'(meta_out_valid), 64'd0);
    check("t1_pop_count", 64'(count), 64'd0);

    // 2. fill, stall threshold, drop on full, drain order
    meta_out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      sop_pulse = 1'b1; meta_in = 64'(i);
      tick();
      check("t2_count", 64'(count), 64'(i));
      check("t2_stall", 64'(stall_out), (i >= 7) ? 64'd1 : 64'd0);
    end
    meta_in = 64'h99;
    tick();
    check("t2_drop", 64'(drop_cnt), 64'd1);
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_head", meta_out, 64'd1);
    sop_pulse = 1'b0; meta_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain", meta_out, 64'(i));
      tick();
    end
    meta_out_ready = 1'b0;
    check("t2_empty_count", 64'(count), 64'd0);
    check("t2_empty_stall", 64'(stall_out), 64'd0);

    // 3. push and pop together while full
    for (int i = 1; i <= 8; i++) begin
      sop_pulse = 1'b1; meta_in = 64'(i);
      tick();
    end
    meta_in = 64'd9; meta_out_ready = 1'b1;
    check("t3_head_before", meta_out, 64'd1);
    tick();
    check("t3_count", 64'(count), 64'd8);
    check("t3_drop", 64'(drop_cnt), 64'd1);
    check("t3_stall", 64'(stall_out), 64'd1);
    sop_pulse = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      check("t3_drain", meta_out, 64'(i));
      tick();
    end
    check("t3_empty_count", 64'(count), 64'd0);

    // 4. backpressure hold
    meta_out_ready = 1'b0; sop_pulse = 1'b1; meta_in = 64'h44;
    tick();
    sop_pulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_data", meta_out, 64'h44);
      check("t4_hold_count", 64'(count), 64'd1);
      check("t4_hold_valid", 64'(meta_out_valid), 64'd1);
    end
    meta_out_ready = 1'b1;
    tick();
    check("t4_pop_count", 64'(count), 64'd0);
    check("t4_pop_valid", 64'(meta_out_valid), 64'd0);

    // 5. wrap-around with random idle gaps
    do_reset();
    meta_out_ready = 1'b0; sop_pulse = 1'b1; meta_in = 64'd0;
    tick();
    sop_pulse = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        check("t5_gap_count", 64'(count <= 4'd2), 64'd1);
      end
      sop_pulse = 1'b1; meta_in = 64'(n); meta_out_ready = 1'b1;
      check("t5_order", meta_out, 64'(n - 1));
      tick();
      check("t5_count", 64'(count), 64'd1);
      sop_pulse = 1'b0; meta_out_ready = 1'b0;
    end
    meta_out_ready = 1'b1;
    check("t5_last", meta_out, 64'd19);
    tick();
    meta_out_ready = 1'b0;
    check("t5_final_count", 64'(count), 64'd0);
    check("t5_drop", 64'(drop_cnt), 64'd0);

    // 6. reset mid-operation
    for (int i = 0; i < 3; i++) begin
      sop_pulse = 1'b1; meta_in = 64'(8'h30 + i);
      tick();
    end
    sop_pulse = 1'b0;
    check("t6_count_before", 64'(count), 64'd3);
    do_reset();
    check_idle("t6_reset");
    sop_pulse = 1'b1; meta_in = 64'h77;
    tick();
    sop_pulse = 1'b0;
    check("t6_first_data", meta_out, 64'h77);
    check("t6_first_count", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_meta_sop_queue
